char_sequencer: RTL
===================

// Module: char_sequencer
// PURPOSE
//  Clocked successor to the combinational character mux of the POV LED display.
//  Holds an N_CHARS-character string plus an effect field in a double buffer and steps through
//  the characters on column/segment strobes.
//  Restarts at the revolution sync.
//  Optionally scrolls the string by one character per revolution.
//  Feeds the glyph ROM / column driver with one registered character code at a time.
// PARAMETERS
//  N_CHARS  10  characters per string (>=2)
//  CHAR_W   7   bits per character code
//  EFX_W    7   bits of effect field, packed above the characters
//  IDX_W    4   index width; must satisfy 2**IDX_W >= N_CHARS
// PORTS
//  clk        in   1                     system clock, rising edge
//  rst_n      in   1                     asynchronous, active-low reset
//  string_in  in   N_CHARS*CHAR_W+EFX_W  char k at [k*CHAR_W +: CHAR_W]; effect at top EFX_W bits
//  load       in   1                     1-cycle strobe: capture string_in into pending buffer
//  step       in   1                     1-cycle strobe: advance to next character
//  sync       in   1                     1-cycle strobe: revolution mark (frame boundary)
//  scroll_en  in   1                     1 = rotate start offset by +1 at each sync
//  ascci      out  CHAR_W                current character code (registered)
//  efect      out  EFX_W                 effect field of the active string (registered)
//  n_ascci    out  IDX_W                 current position 0..N_CHARS-1 (registered)
//  char_valid out  1                     1 while in RUN
//  frame_done out  1                     1-cycle pulse when index wraps N_CHARS-1 -> 0 on step
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE, all buffers 0, pend_flag=0, idx=0, base=0.
//   - All outputs 0 for as long as rst_n=0.
//   - Reset mid-frame discards active and pending strings; a new load is needed.
//  States
//   - IDLE: outputs held 0; step/sync ignored.
//     load -> active<=string_in, state RUN, idx=0, base=0.
//   - RUN: operation as below. No other states; only reset returns to IDLE.
//  Buffering (RUN)
//   - load writes pending buffer and sets pend_flag; a later load before sync overwrites it.
//   - On sync with pend_flag=1: active<=pending, pend_flag<=0, base<=0.
//     The new string displays from its char 0; no tearing mid-revolution.
//   - load and sync in the same cycle: the sync commits the OLD pending (if any).
//     The new data lands in pending and commits at the next sync.
//  Indexing (RUN, priority sync > step)
//   - sync:
//     - idx<=0.
//     - If scroll_en=1 and no commit this cycle: base<=(base+1) mod N_CHARS.
//     - scroll_en=0 holds base.
//   - step without sync:
//     - idx<=idx+1.
//     - At idx=N_CHARS-1: idx<=0 and frame_done=1 for one cycle.
//   - sync and step in the same cycle: sync wins; the step is dropped; no frame_done.
//  Output mapping and latency
//   - ascci = active char[(base+idx) mod N_CHARS].
//     Mod is a compare/subtract; no divider; base+idx fits IDX_W+1 bits.
//   - ascci, efect, n_ascci, char_valid and frame_done are registered from next-state values.
//     A strobe sampled at edge k is visible immediately after edge k (latency 1 clk).
//   - efect always reflects the active buffer; it changes only on commit.
//   - IDLE->RUN: the first char appears the edge after load, with char_valid=1.
// TESTING
//  1. N=10, W=7: reset, load "HELLOWORLD" (char0='H'=7'h48), efect=7'h05.
//     -> next clk: ascci=7'h48, efect=7'h05, n_ascci=0, char_valid=1.
//  2. 10 steps after test 1 -> ascci E,L,L,O,W,O,R,L,D,H; n_ascci 1..9,0.
//     frame_done pulses exactly once, at the 9->0 step.
//  3. scroll_en=1, 3 syncs -> base=3; after the 3rd sync ascci='L'(char3), n_ascci=0.
//     7 steps then reach base+idx=10 -> wraps to char0 'H'.
//  4. Mid-frame at idx=4: load "ABCDEFGHIJ" -> ascci unchanged until sync.
//     At sync: ascci='A', base=0, efect=new value.
//     Also: load+sync same cycle -> old pending commits; new one commits at the next sync.
//  5. sync and step same cycle at idx=9 -> n_ascci=0, no frame_done.
//     step/sync while in IDLE -> all outputs stay 0.
//  6. rst_n low asynchronously mid-frame (no clk edge) -> outputs 0 immediately, state IDLE.
//     After release, step does nothing until load.

Source files
------------

// File: rtl/char_sequencer.sv
// Double-buffered character sequencer: steps through an N_CHARS string on strobes, restarts and optionally scrolls at sync.
// Latency: one clock from strobe to registered outputs. No backpressure; strobes are always accepted.
module char_sequencer #(
    parameter int N_CHARS = 10,
    parameter int CHAR_W  = 7,
    parameter int EFX_W   = 7,
    parameter int IDX_W   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_CHARS*CHAR_W+EFX_W-1:0]   string_in,
    input  logic                              load,
    input  logic                              step,
    input  logic                              sync,
    input  logic                              scroll_en,
    output logic [CHAR_W-1:0]                 ascci,
    output logic [EFX_W-1:0]                  efect,
    output logic [IDX_W-1:0]                  n_ascci,
    output logic                              char_valid,
    output logic                              frame_done
);

    localparam int STR_W = N_CHARS*CHAR_W + EFX_W;
    localparam logic [IDX_W:0]   N_SUM    = (IDX_W+1)'(N_CHARS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHARS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, nxt_state;
    logic [STR_W-1:0]   active, nxt_active;
    logic [STR_W-1:0]   pending, nxt_pending;
    logic               pend_flag, nxt_pend_flag;
    logic [IDX_W-1:0]   idx, nxt_idx;
    logic [IDX_W-1:0]   base, nxt_base;
    logic               nxt_fd;
    logic               commit;
    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   sel;
    logic [CHAR_W-1:0]  nxt_char;

    always_comb begin
        nxt_state     = state;
        nxt_active    = active;
        nxt_pending   = pending;
        nxt_pend_flag = pend_flag;
        nxt_idx       = idx;
        nxt_base      = base;
        nxt_fd        = 1'b0;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    nxt_active = string_in;
                    nxt_state  = RUN;
                    nxt_idx    = '0;
                    nxt_base   = '0;
                end
            end
            default: begin
                // A sync commits whatever was pending before this cycle's load.
                commit = sync & pend_flag;
                if (commit) begin
                    nxt_active    = pending;
                    nxt_pend_flag = 1'b0;
                    nxt_base      = '0;
                end
                if (load) begin
                    nxt_pending   = string_in;
                    nxt_pend_flag = 1'b1;
                end
                if (sync) begin
                    nxt_idx = '0;
                    if (scroll_en && !commit)
                        nxt_base = (base == LAST_IDX) ? '0 : base + 1'b1;
                end else if (step) begin
                    if (idx == LAST_IDX) begin
                        nxt_idx = '0;
                        nxt_fd  = 1'b1;
                    end else begin
                        nxt_idx = idx + 1'b1;
                    end
                end
            end
        endcase

        sum      = {1'b0, nxt_base} + {1'b0, nxt_idx};
        sel      = (sum >= N_SUM) ? IDX_W'(sum - N_SUM) : IDX_W'(sum);
        nxt_char = '0;
        for (int k = 0; k < N_CHARS; k++)
            if (sel == IDX_W'(k))
                nxt_char = nxt_active[k*CHAR_W +: CHAR_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            active     <= '0;
            pending    <= '0;
            pend_flag  <= 1'b0;
            idx        <= '0;
            base       <= '0;
            ascci      <= '0;
            efect      <= '0;
            n_ascci    <= '0;
            char_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            active     <= nxt_active;
            pending    <= nxt_pending;
            pend_flag  <= nxt_pend_flag;
            idx        <= nxt_idx;
            base       <= nxt_base;
            char_valid <= (nxt_state == RUN);
            if (nxt_state == RUN) begin
                ascci      <= nxt_char;
                efect      <= nxt_active[N_CHARS*CHAR_W +: EFX_W];
                n_ascci    <= nxt_idx;
                frame_done <= nxt_fd;
            end else begin
                ascci      <= '0;
                efect      <= '0;
                n_ascci    <= '0;
                frame_done <= 1'b0;
            end
        end
    end

endmodule
